// File: rtl/mult_div_if.sv
// HI/LO-class operation interface between the E stage and the multiply/divide unit.
// The E stage drives start/op/A/B; the unit returns busy and the HI/LO registers.
interface mult_div_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, A, B, input busy, hi, lo);
    modport slave  (input start, op, A, B, output busy, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs mult/multu/div/divu with a
// fixed busy latency and applies mthi/mtlo immediately.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | accepting a new HI/LO-class op; busy low
// BUSY  | result held in pending register, counting down to commit
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mult_div_if.slave  bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [63:0]        pend, pend_nxt;
    logic               pend_ok, pend_ok_nxt;
    logic [31:0]        hi_q, hi_nxt;
    logic [31:0]        lo_q, lo_nxt;

    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, divu_b, divs_b;
    logic [31:0] uq, ur, sq_mag, sr_mag, sq, sr;
    logic        b_zero;

    // Signed product via explicit sign extension keeps the math in one unsigned width.
    assign prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    assign prod_u = {32'b0, bus.A} * {32'b0, bus.B};

    // Divisor forced to 1 on zero so the datapath never produces X; the result is discarded.
    assign b_zero = (bus.B == 32'd0);
    assign divu_b = b_zero ? 32'd1 : bus.B;
    assign abs_a  = bus.A[31] ? -bus.A : bus.A;
    assign abs_b  = bus.B[31] ? -bus.B : bus.B;
    assign divs_b = b_zero ? 32'd1 : abs_b;

    assign uq     = bus.A / divu_b;
    assign ur     = bus.A % divu_b;
    assign sq_mag = abs_a / divs_b;
    assign sr_mag = abs_a % divs_b;
    // 0x80000000 / -1 lands on quotient 0x80000000, remainder 0 without a special case.
    assign sq     = (bus.A[31] ^ bus.B[31]) ? -sq_mag : sq_mag;
    assign sr     = bus.A[31] ? -sr_mag : sr_mag;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pend    <= '0;
            pend_ok <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pend    <= pend_nxt;
            pend_ok <= pend_ok_nxt;
            hi_q    <= hi_nxt;
            lo_q    <= lo_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pend_nxt    = pend;
        pend_ok_nxt = pend_ok;
        hi_nxt      = hi_q;
        lo_nxt      = lo_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT: begin
                            pend_nxt    = prod_s;
                            pend_ok_nxt = 1'b1;
                            cnt_nxt     = CNT_W'(MULT_CYCLES);
                            state_nxt   = BUSY;
                        end
                        OP_MULTU: begin
                            pend_nxt    = prod_u;
                            pend_ok_nxt = 1'b1;
                            cnt_nxt     = CNT_W'(MULT_CYCLES);
                            state_nxt   = BUSY;
                        end
                        OP_DIV: begin
                            pend_nxt    = {sr, sq};
                            pend_ok_nxt = ~b_zero;
                            cnt_nxt     = CNT_W'(DIV_CYCLES);
                            state_nxt   = BUSY;
                        end
                        OP_DIVU: begin
                            pend_nxt    = {ur, uq};
                            pend_ok_nxt = ~b_zero;
                            cnt_nxt     = CNT_W'(DIV_CYCLES);
                            state_nxt   = BUSY;
                        end
                        OP_MTHI: hi_nxt = bus.A;
                        OP_MTLO: lo_nxt = bus.A;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                if (cnt <= CNT_W'(1)) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    pend_ok_nxt = 1'b0;
                    if (pend_ok) begin
                        hi_nxt = pend[63:32];
                        lo_nxt = pend[31:0];
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy = (state == BUSY);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
